data_memory_bytewise: RTL and testbench

- Parametrised successor to the simple word memory used by the datapath: a single-port data memory with configurable data width, depth and byte-lane write enables.
- Read data is registered, with a read-valid strobe.
- Misaligned and out-of-range accesses are flagged and dropped.
- An optional post-reset clear sweep zeroes the array before accepting requests.
- Sits between the core's load/store unit and the memory array.

---
 rtl/data_memory_bytewise.sv | 110 +++++++++++
 tb/tb_data_memory_bytewise.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bytewise.sv
// Single-port data memory with byte-lane writes, registered reads, request
// validation and an optional zeroing sweep after reset.
module data_memory_bytewise #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DEPTH          = 256,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH/8-1:0] byteEnable,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    readValid,
    output logic                    busy,
    output logic                    accessError
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned B     = $clog2(BYTES);
    localparam int unsigned W     = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((64'd1 << B) - 64'd1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic   [W-1:0]        clear_cnt;
    logic                  clear_we;
    logic                  started;
    logic   [DATA_WIDTH-1:0] mem [DEPTH];
    logic   [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  access_error;

    logic                  aligned;
    logic                  in_range;
    logic   [W-1:0]        word_idx;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  bad_req;

    // started keeps busy high through reset even when no sweep is configured
    assign busy = !started || (state == CLEAR);

    assign aligned  = (Address & OFFSET_MASK) == '0;
    assign in_range = (Address >> (B + W)) == '0;
    assign word_idx = W'(Address >> B);

    assign rd_ok   = !busy && MemRead && !MemWrite && aligned && in_range;
    assign wr_ok   = !busy && MemWrite && !MemRead && aligned && in_range;
    assign bad_req = !busy && (MemRead || MemWrite)
                     && ((MemRead && MemWrite) || !aligned || !in_range);

    always_comb begin
        next_state = state;
        clear_we   = 1'b0;
        case (state)
            CLEAR: begin
                clear_we = 1'b1;
                if (clear_cnt == W'(DEPTH - 1))
                    next_state = IDLE;
            end
            IDLE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clear_cnt    <= '0;
            started      <= 1'b0;
            read_data    <= '0;
            read_valid   <= 1'b0;
            access_error <= 1'b0;
        end else begin
            state        <= next_state;
            started      <= 1'b1;
            if (state == CLEAR)
                clear_cnt <= clear_cnt + W'(1);
            read_valid   <= rd_ok;
            access_error <= bad_req;
            if (rd_ok)
                read_data <= mem[word_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (clear_we) begin
            mem[clear_cnt] <= '0;
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (byteEnable[i])
                    mem[word_idx][8*i +: 8] <= writeData[8*i +: 8];
            end
        end
    end

    assign ReadData    = read_data;
    assign readValid   = read_valid;
    assign accessError = access_error;

endmodule

// File: tb/tb_data_memory_bytewise.sv
// Randomised self-checking bench for data_memory_bytewise against a word-array
// reference model using byte-address arithmetic.
module tb_data_memory_bytewise;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] writeData = '0;
    logic [3:0]  byteEnable = '0;
    logic [31:0] ReadData;
    logic        readValid;
    logic        busy;
    logic        accessError;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [31:0] model_mem [256];
    logic [31:0] exp_data = '0;

    data_memory_bytewise #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH(256),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .Address(Address),
        .writeData(writeData),
        .byteEnable(byteEnable),
        .ReadData(ReadData),
        .readValid(readValid),
        .busy(busy),
        .accessError(accessError)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expected);
        vectors++;
        if (got !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, expected, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        exp_data = '0;
    endtask

    // One request cycle: drive at negedge, sample edge, check at next negedge.
    task automatic do_cycle(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        logic ok_addr;
        logic exp_rv;
        logic exp_err;
        MemRead    = rd;
        MemWrite   = wr;
        Address    = addr;
        writeData  = wdata;
        byteEnable = be;
        @(posedge clock);
        ok_addr = (addr % 4 == 0) && (addr < 32'd1024);
        exp_rv  = 1'b0;
        exp_err = 1'b0;
        if (rd || wr) begin
            if ((rd && wr) || !ok_addr) begin
                exp_err = 1'b1;
            end else if (rd) begin
                exp_rv   = 1'b1;
                exp_data = model_mem[addr / 4];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[addr / 4][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        @(negedge clock);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        check_val("readValid", {31'b0, readValid}, {31'b0, exp_rv});
        check_val("accessError", {31'b0, accessError}, {31'b0, exp_err});
        check_val("ReadData", ReadData, exp_data);
        check_val("busy", {31'b0, busy}, 32'd0);
    endtask

    // Release reset at a negedge and count edges until busy drops; one write is
    // attempted mid-sweep and must be dropped without a strobe.
    task automatic release_and_sweep(input int drop_at);
        int unsigned cnt;
        int unsigned strobes;
        cnt     = 0;
        strobes = 0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (i == drop_at) begin
                MemWrite = 1'b1; Address = 32'h10; writeData = 32'hFFFF_FFFF; byteEnable = 4'hF;
            end
            @(posedge clock);
            @(negedge clock);
            MemWrite = 1'b0;
            cnt++;
            if (readValid || accessError) strobes++;
            if (!busy) break;
        end
        check_val("busy_cycles", cnt, 32'd256);
        check_val("sweep_strobes", strobes, 32'd0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] wdata;
        int          sel;
        model_clear();

        #1 reset_n = 1'b0;
        #11;
        check_val("rst_busy", {31'b0, busy}, 32'd1);
        check_val("rst_readValid", {31'b0, readValid}, 32'd0);
        check_val("rst_accessError", {31'b0, accessError}, 32'd0);
        check_val("rst_ReadData", ReadData, 32'd0);

        release_and_sweep(10);
        do_cycle(1, 0, 32'h3FC, '0, 4'h0);
        do_cycle(1, 0, 32'h10, '0, 4'h0);

        do_cycle(0, 1, 32'h04, 32'h2, 4'hF);
        do_cycle(0, 1, 32'h08, 32'h5, 4'hF);
        do_cycle(0, 1, 32'h0C, 32'h9, 4'hF);
        do_cycle(0, 1, 32'h18, 32'h7, 4'hF);
        do_cycle(0, 1, 32'h1C, 32'hA, 4'hF);
        do_cycle(1, 0, 32'h18, '0, 4'h0);
        do_cycle(1, 0, 32'h04, '0, 4'h0);
        do_cycle(1, 0, 32'h1C, '0, 4'h0);
        do_cycle(1, 0, 32'h08, '0, 4'h0);
        do_cycle(1, 0, 32'h0C, '0, 4'h0);

        do_cycle(0, 1, 32'h20, 32'hAABBCCDD, 4'hF);
        do_cycle(0, 1, 32'h20, 32'h11223344, 4'h5);
        do_cycle(1, 0, 32'h20, '0, 4'h0);
        check_val("byte_lanes", ReadData, 32'hAA22CC44);

        do_cycle(1, 0, 32'h22, '0, 4'h0);
        do_cycle(0, 1, 32'h400, 32'hDEAD_0000, 4'hF);
        do_cycle(1, 0, 32'h00, '0, 4'h0);
        do_cycle(1, 1, 32'h04, 32'h1234_5678, 4'hF);
        do_cycle(1, 0, 32'h04, '0, 4'h0);
        do_cycle(0, 1, 32'h08, 32'h0, 4'h0);
        do_cycle(1, 0, 32'h08, '0, 4'h0);

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 5)       addr = $urandom_range(0, 15) * 4;
            else if (sel < 7)  addr = $urandom_range(0, 255) * 4;
            else if (sel == 7) addr = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
            else if (sel == 8) addr = $urandom | 32'h400;
            else               addr = $urandom;
            wdata = $urandom;
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, wdata,
                     4'($urandom_range(0, 15)));
        end

        do_cycle(0, 1, 32'h30, 32'hDEADBEEF, 4'hF);
        MemRead = 1'b1; Address = 32'h30;
        @(posedge clock);
        #2;
        check_val("pre_rst_readValid", {31'b0, readValid}, 32'd1);
        check_val("pre_rst_ReadData", ReadData, 32'hDEADBEEF);
        reset_n = 1'b0;
        #1;
        MemRead = 1'b0;
        check_val("async_ReadData", ReadData, 32'd0);
        check_val("async_readValid", {31'b0, readValid}, 32'd0);
        check_val("async_accessError", {31'b0, accessError}, 32'd0);
        check_val("async_busy", {31'b0, busy}, 32'd1);
        model_clear();
        release_and_sweep(-1);
        do_cycle(1, 0, 32'h30, '0, 4'h0);
        do_cycle(1, 0, 32'h00, '0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
